// File: rtl/kernel_fdtd_2d_mul_pipe_if.sv
// Operand/result handshake bundle for kernel_fdtd_2d_mul_pipe.
// master: operand producer and result consumer (drives in_valid, din0, din1,
//         signed_mode, acc_en, out_ready).
// slave : the multiply pipe (drives in_ready, out_valid, dout, ovf).
interface kernel_fdtd_2d_mul_pipe_if #(
    parameter int DIN0_WIDTH = 10,
    parameter int DIN1_WIDTH = 11,
    parameter int DOUT_WIDTH = 24
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  signed_mode;
    logic                  acc_en;
    logic                  out_valid;
    logic                  out_ready;
    logic [DOUT_WIDTH-1:0] dout;
    logic                  ovf;

    modport master (
        output in_valid, din0, din1, signed_mode, acc_en, out_ready,
        input  in_ready, out_valid, dout, ovf
    );

    modport slave (
        input  in_valid, din0, din1, signed_mode, acc_en, out_ready,
        output in_ready, out_valid, dout, ovf
    );
endinterface

// File: rtl/kernel_fdtd_2d_mul_pipe.sv
// Pipelined signed/unsigned multiply with optional running accumulate for the
// fdtd-2d datapath. Accept-to-out_valid latency is NUM_STAGE cycles.
// Ports:
//   clk   - clock, all state on rising edge
//   reset - asynchronous active-high reset
//   ce    - global enable; 0 freezes every register and blocks handshakes
//   bus   - slave side of the operand/result handshake interface
module kernel_fdtd_2d_mul_pipe #(
    parameter int DIN0_WIDTH = 10,
    parameter int DIN1_WIDTH = 11,
    parameter int DOUT_WIDTH = 24,
    parameter int NUM_STAGE  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    kernel_fdtd_2d_mul_pipe_if.slave  bus
);
    localparam int PW   = DIN0_WIDTH + DIN1_WIDTH;
    localparam int LAST = NUM_STAGE - 1;

    logic                  w_adv;
    logic                  r_out_valid;
    logic [DOUT_WIDTH-1:0] r_dout;
    logic                  r_ovf;

    logic                  r_s1_vld;
    logic [DIN0_WIDTH-1:0] r_s1_din0;
    logic [DIN1_WIDTH-1:0] r_s1_din1;
    logic                  r_s1_sgn;
    logic                  r_s1_acc;

    // Index 2 is the product register, 3..LAST are pure delay stages.
    logic [PW-1:0] r_p_prod [2:LAST];
    logic          r_p_vld  [2:LAST];
    logic          r_p_sgn  [2:LAST];
    logic          r_p_acc  [2:LAST];

    logic [PW-1:0]         w_op0;
    logic [PW-1:0]         w_op1;
    logic [PW-1:0]         w_prod;
    logic [PW-1:0]         w_p_last;
    logic [DOUT_WIDTH-1:0] w_p_ext;
    logic [DOUT_WIDTH:0]   w_sum;
    logic                  w_ovf_s;
    logic                  w_ovf;

    // Whole pipe moves together; bubbles are never squeezed out.
    assign w_adv        = ce && !reset && (!r_out_valid || bus.out_ready);
    assign bus.in_ready = w_adv;
    assign bus.out_valid = r_out_valid;
    assign bus.dout      = r_dout;
    assign bus.ovf       = r_ovf;

    // Extending both operands to the full product width makes the low PW
    // bits of a plain multiply correct for both signed and unsigned operands.
    assign w_op0  = r_s1_sgn ? {{DIN1_WIDTH{r_s1_din0[DIN0_WIDTH-1]}}, r_s1_din0}
                             : {{DIN1_WIDTH{1'b0}}, r_s1_din0};
    assign w_op1  = r_s1_sgn ? {{DIN0_WIDTH{r_s1_din1[DIN1_WIDTH-1]}}, r_s1_din1}
                             : {{DIN0_WIDTH{1'b0}}, r_s1_din1};
    assign w_prod = w_op0 * w_op1;

    assign w_p_last = r_p_prod[LAST];

    generate
        if (DOUT_WIDTH > PW) begin : g_ext
            assign w_p_ext = {{(DOUT_WIDTH-PW){r_p_sgn[LAST] & w_p_last[PW-1]}}, w_p_last};
        end else begin : g_trunc
            assign w_p_ext = w_p_last[DOUT_WIDTH-1:0];
        end
    endgenerate

    // r_dout doubles as the accumulator: after any valid beat they are equal,
    // and both hold across bubbles and stalls.
    assign w_sum   = {1'b0, r_dout} + {1'b0, w_p_ext};
    assign w_ovf_s = (r_dout[DOUT_WIDTH-1] == w_p_ext[DOUT_WIDTH-1]) &&
                     (w_sum[DOUT_WIDTH-1] != r_dout[DOUT_WIDTH-1]);
    assign w_ovf   = r_p_sgn[LAST] ? w_ovf_s : w_sum[DOUT_WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_vld    <= 1'b0;
            r_s1_din0   <= '0;
            r_s1_din1   <= '0;
            r_s1_sgn    <= 1'b0;
            r_s1_acc    <= 1'b0;
            for (int i = 2; i <= LAST; i++) begin
                r_p_prod[i] <= '0;
                r_p_vld[i]  <= 1'b0;
                r_p_sgn[i]  <= 1'b0;
                r_p_acc[i]  <= 1'b0;
            end
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_ovf       <= 1'b0;
        end else if (w_adv) begin
            r_s1_vld  <= bus.in_valid;
            r_s1_din0 <= bus.din0;
            r_s1_din1 <= bus.din1;
            r_s1_sgn  <= bus.signed_mode;
            r_s1_acc  <= bus.acc_en;

            r_p_prod[2] <= w_prod;
            r_p_vld[2]  <= r_s1_vld;
            r_p_sgn[2]  <= r_s1_sgn;
            r_p_acc[2]  <= r_s1_acc;
            for (int i = 3; i <= LAST; i++) begin
                r_p_prod[i] <= r_p_prod[i-1];
                r_p_vld[i]  <= r_p_vld[i-1];
                r_p_sgn[i]  <= r_p_sgn[i-1];
                r_p_acc[i]  <= r_p_acc[i-1];
            end

            r_out_valid <= r_p_vld[LAST];
            if (r_p_vld[LAST]) begin
                if (r_p_acc[LAST]) begin
                    r_dout <= w_sum[DOUT_WIDTH-1:0];
                    r_ovf  <= w_ovf;
                end else begin
                    r_dout <= w_p_ext;
                    r_ovf  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_kernel_fdtd_2d_mul_pipe.sv
// Self-checking bench for kernel_fdtd_2d_mul_pipe: directed cases plus a
// randomized stream, all compared against an arithmetic reference model.
module tb_kernel_fdtd_2d_mul_pipe;
    localparam int D0 = 10;
    localparam int D1 = 11;
    localparam int DW = 24;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic reset;
    logic ce;

    kernel_fdtd_2d_mul_pipe_if #(.DIN0_WIDTH(D0), .DIN1_WIDTH(D1), .DOUT_WIDTH(DW)) bus ();

    kernel_fdtd_2d_mul_pipe #(
        .DIN0_WIDTH(D0), .DIN1_WIDTH(D1), .DOUT_WIDTH(DW), .NUM_STAGE(NS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] res;
        bit            ovf;
        int            acc_cyc;
    } exp_t;

    int            n_chk  = 0;
    int            n_fail = 0;
    exp_t          q[$];
    logic [DW-1:0] popped[$];
    bit            popped_ovf[$];
    longint        m_acc = 0;
    bit            chk_lat = 0;
    bit            last_acc = 0;
    bit            held = 0;
    logic [DW-1:0] held_dout;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: exact integer product, reduced mod 2^DW, accumulated with
    // range checks on the mathematical sum.
    task automatic model_push(input longint d0, input longint d1, input bit sm, input bit ae);
        longint mask, a, b, p, sum, sa, sp, half;
        exp_t   e;
        mask = (64'sd1 <<< DW) - 1;
        half = 64'sd1 <<< (DW - 1);
        a = d0;
        b = d1;
        if (sm && a >= (64'sd1 <<< (D0 - 1))) a -= (64'sd1 <<< D0);
        if (sm && b >= (64'sd1 <<< (D1 - 1))) b -= (64'sd1 <<< D1);
        p = (a * b) & mask;
        if (!ae) begin
            e.res = p[DW-1:0];
            e.ovf = 1'b0;
        end else if (!sm) begin
            sum   = m_acc + p;
            e.ovf = (sum > mask);
            e.res = sum[DW-1:0];
        end else begin
            sa    = (m_acc >= half) ? m_acc - (64'sd1 <<< DW) : m_acc;
            sp    = (p >= half) ? p - (64'sd1 <<< DW) : p;
            sum   = sa + sp;
            e.ovf = (sum >= half) || (sum < -half);
            e.res = sum[DW-1:0];
        end
        m_acc     = longint'(e.res);
        e.acc_cyc = cyc + 1;
        q.push_back(e);
    endtask

    // Inputs are driven at the falling edge; everything is sampled 1 time
    // unit later, well before the next rising edge.
    task automatic step();
        exp_t e;
        #1;
        check_val("in_ready", bus.in_ready, ce && !reset && (!bus.out_valid || bus.out_ready));
        if (held && !reset) begin
            check_val("stall_out_valid", bus.out_valid, 1);
            check_val("stall_dout", bus.dout, held_dout);
        end
        last_acc = 1'b0;
        if (bus.in_valid && bus.in_ready) begin
            model_push(longint'(bus.din0), longint'(bus.din1), bus.signed_mode, bus.acc_en);
            last_acc = 1'b1;
        end
        if (bus.out_valid && bus.out_ready && ce && !reset) begin
            if (q.size() == 0) begin
                check_val("spurious_out_valid", bus.out_valid, 0);
            end else begin
                e = q.pop_front();
                check_val("dout", bus.dout, e.res);
                check_val("ovf", bus.ovf, e.ovf);
                if (chk_lat) check_val("latency_edges", cyc - e.acc_cyc, NS - 1);
            end
            popped.push_back(bus.dout);
            popped_ovf.push_back(bus.ovf);
        end
        held      = bus.out_valid && !(bus.out_ready && ce) && !reset;
        held_dout = bus.dout;
        @(negedge clk);
    endtask

    task automatic send(input int d0, input int d1, input bit sm, input bit ae);
        bus.in_valid    = 1'b1;
        bus.din0        = d0[D0-1:0];
        bus.din1        = d1[D1-1:0];
        bus.signed_mode = sm;
        bus.acc_en      = ae;
        for (int t = 0; t < 50; t++) begin
            step();
            if (last_acc) return;
        end
        check_val("send_timeout", last_acc, 1);
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        ce            = 1'b1;
        for (int t = 0; t < 40 && (q.size() > 0 || bus.out_valid); t++) step();
        check_val("drain_queue_empty", q.size(), 0);
        check_val("drain_out_valid", bus.out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c;
        reset           = 1'b1;
        ce              = 1'b1;
        bus.in_valid    = 1'b0;
        bus.din0        = '0;
        bus.din1        = '0;
        bus.signed_mode = 1'b0;
        bus.acc_en      = 1'b0;
        bus.out_ready   = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_dout", bus.dout, 0);
        check_val("rst_ovf", bus.ovf, 0);
        check_val("rst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic unsigned product with latency check.
        chk_lat = 1'b1;
        popped.delete(); popped_ovf.delete();
        send(1023, 2047, 0, 0);
        drain();
        check_val("t1_count", popped.size(), 1);
        check_val("t1_dout", popped[0], 24'h1FF401);
        check_val("t1_ovf", popped_ovf[0], 0);

        // Signed vs unsigned interpretation of the same bits.
        popped.delete(); popped_ovf.delete();
        send(10'h3FF, 5, 1, 0);
        send(10'h3FF, 5, 0, 0);
        drain();
        check_val("t2_signed", popped[0], 24'hFFFFFB);
        check_val("t2_unsigned", popped[1], 5115);

        // Back-to-back MAC: results on consecutive cycles via latency checks.
        popped.delete(); popped_ovf.delete();
        send(3, 4, 0, 0);
        send(5, 6, 0, 1);
        send(2, 2, 0, 0);
        drain();
        check_val("t3_r0", popped[0], 12);
        check_val("t3_r1", popped[1], 42);
        check_val("t3_r2", popped[2], 4);

        // Unsigned accumulate wrap on the ninth beat.
        popped.delete(); popped_ovf.delete();
        for (int i = 0; i < 9; i++) send(1023, 2047, 0, (i != 0));
        drain();
        check_val("t4_count", popped.size(), 9);
        check_val("t4_r7", popped[7], 16752648);
        check_val("t4_ovf7", popped_ovf[7], 0);
        check_val("t4_r8", popped[8], 2069513);
        check_val("t4_ovf8", popped_ovf[8], 1);
        chk_lat = 1'b0;

        // out_ready low for 5 cycles mid-stream.
        popped.delete(); popped_ovf.delete();
        n = 0; c = 0;
        while (n < 8 && c < 100) begin
            bus.in_valid    = 1'b1;
            bus.din0        = D0'(n + 10);
            bus.din1        = D1'(n + 3);
            bus.signed_mode = 1'b0;
            bus.acc_en      = 1'b0;
            bus.out_ready   = !(c >= 4 && c < 9);
            step();
            if (last_acc) n++;
            c++;
        end
        drain();
        check_val("t5_backpressure_count", popped.size(), 8);

        // ce low for 3 cycles mid-stream.
        popped.delete(); popped_ovf.delete();
        n = 0; c = 0;
        while (n < 8 && c < 100) begin
            bus.in_valid    = 1'b1;
            bus.din0        = D0'(3 * n + 1);
            bus.din1        = D1'(n + 100);
            bus.signed_mode = n[0];
            bus.acc_en      = (n != 0);
            ce              = !(c >= 4 && c < 7);
            step();
            if (last_acc) n++;
            c++;
        end
        drain();
        check_val("t6_ce_count", popped.size(), 8);

        // Reset between edges with beats in flight.
        send(9, 9, 0, 0);
        send(8, 8, 0, 1);
        send(7, 7, 0, 1);
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_val("midrst_out_valid", bus.out_valid, 0);
        check_val("midrst_dout", bus.dout, 0);
        check_val("midrst_in_ready", bus.in_ready, 0);
        q.delete();
        m_acc = 0;
        held  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        popped.delete(); popped_ovf.delete();
        send(7, 3, 0, 1);
        drain();
        check_val("postrst_acc_from_zero", popped[0], 21);

        // Randomized traffic with random backpressure and enable.
        for (int t = 0; t < 400; t++) begin
            bus.in_valid    = ($urandom % 4) != 0;
            bus.din0        = D0'($urandom);
            bus.din1        = D1'($urandom);
            bus.signed_mode = $urandom % 2;
            bus.acc_en      = ($urandom % 4) != 0;
            bus.out_ready   = ($urandom % 4) != 0;
            ce              = ($urandom % 8) != 0;
            step();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/kernel_fdtd_2d_mul_pipe.md
Name: kernel_fdtd_2d_mul_pipe

Overview:
- Parametrised pipelined multiply / multiply-accumulate unit for the fdtd-2d kernel datapath. It is the successor to the fixed 10x11 unsigned DSP48 multiplier.
- Adds configurable operand, result and pipeline widths/depth, a per-operation signed/unsigned mode, and an optional running accumulate.
- Uses a valid/ready handshake with backpressure in place of a bare clock enable.
- Sits between the address/coefficient generators and the stencil update arithmetic.

Parameters:
- DIN0_WIDTH, 10, width of operand din0.
- DIN1_WIDTH, 11, width of operand din1.
- DOUT_WIDTH, 24, result/accumulator width. Product of width DIN0_WIDTH+DIN1_WIDTH is truncated to low bits or sign/zero-extended to fit.
- NUM_STAGE, 4, accept-to-out_valid latency in cycles; legal range 3..8.

Ports:
- clk, input, 1, clock; all state on rising edge.
- reset, input, 1, asynchronous active-high reset.
- ce, input, 1, global enable; 0 freezes all state.
- in_valid, input, 1, operand beat offered.
- in_ready, output, 1, beat accepted when in_valid && in_ready.
- din0, input, DIN0_WIDTH, multiplicand.
- din1, input, DIN1_WIDTH, multiplier.
- signed_mode, input, 1, 1 = two's-complement operands, 0 = unsigned; sampled with the beat.
- acc_en, input, 1, 1 = add product to accumulator, 0 = start new sum; sampled with the beat.
- out_valid, output, 1, result held valid.
- out_ready, input, 1, consumer accepts when out_valid && out_ready && ce.
- dout, output, DOUT_WIDTH, result.
- ovf, output, 1, the result in dout wrapped on accumulation (per result, not sticky).

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0, out_valid = 0, dout = 0, ovf = 0, accumulator = 0. in_ready = 0 while reset is high. In-flight beats are discarded, including those arriving mid-operation.
- adv = ce && (!out_valid || out_ready). in_ready = adv (combinational). Every pipeline register, valid bit and tag advances only when adv = 1.
- Pipeline structure:
  - Stage 1 registers din0, din1, signed_mode, acc_en and valid.
  - Stage 2 registers the full product: (DIN0_WIDTH+DIN1_WIDTH) bits, signed or unsigned per the tag.
  - Stages 3..NUM_STAGE-1 are pure delay registers.
  - Final stage is the output/accumulate register.
- Latency: a beat accepted at edge k has out_valid = 1 after edge k+NUM_STAGE-1, i.e. it is visible NUM_STAGE cycles after acceptance. Throughput is 1 beat/cycle while out_ready = 1.
- Bubbles are not compressed. A stall freezes the whole pipe, bubbles included.
- Width rule: product p is sign-extended (signed_mode = 1) or zero-extended to DOUT_WIDTH when narrower. It is truncated to its low DOUT_WIDTH bits when wider.
- Output stage, on adv with a valid beat arriving:
  - acc_en = 0: dout = p, accumulator = p, ovf = 0.
  - acc_en = 1: dout = accumulator + p (mod 2^DOUT_WIDTH), accumulator = dout.
    - ovf, unsigned: carry out of DOUT_WIDTH.
    - ovf, signed: operands of equal sign give a result of differing sign.
- Output stage, on adv with a bubble arriving: out_valid = 0, dout and accumulator hold.
- The accumulator changes only when a valid beat enters the output register. It is not affected by bubbles or stalls.
- Simultaneous pop and push (out_valid && out_ready, new beat at final stage): the new result replaces the old in the same cycle with no gap.
- ce = 0: in_ready = 0, no handshake completes, out_valid and dout hold.
- Mixed signed_mode inside one accumulation is legal; each product is interpreted per its own tag.

Test Plan:
- Unsigned, NUM_STAGE = 4: din0 = 1023, din1 = 2047, acc_en = 0, out_ready = 1 -> dout = 24'h1FF401 (2094081), out_valid exactly 4 cycles after acceptance, ovf = 0.
- Signed: din0 = 10'h3FF (-1), din1 = 11'd5, signed_mode = 1 -> dout = 24'hFFFFFB; same operands unsigned -> dout = 5115.
- MAC sequence (3,4,acc_en=0), (5,6,acc_en=1), (2,2,acc_en=0) back-to-back -> dout = 12, 42, 4 on consecutive cycles.
- Overflow: nine unsigned beats of 1023x2047, first with acc_en = 0 -> results 2094081 .. 16752648 with ovf = 0; ninth = 2069513 with ovf = 1.
- Backpressure: stream 8 beats with out_ready low for 5 cycles mid-stream -> in_ready drops while out_valid && !out_ready, dout stable during the stall, all 8 results in order with none lost or duplicated. Also toggle ce = 0 for 3 cycles -> identical freeze.
- Reset mid-stream: assert reset with 3 beats in flight, between clock edges -> out_valid, dout and in_ready go to 0 immediately. After release, the first new beat with acc_en = 1 sums from 0.
